storage_arbiter: RTL and testbench

Two-port arbiter in front of `storage_controller`, sharing the single scratchpad-SRAM / external-QSPI storage path between the scalar core data port (port 0) and the vector unit memory port (port 1). It accepts requests, grants one at a time round-robin, holds downstream address and data stable for the whole transaction, and routes the response back as a registered one-cycle pulse. It also decodes SRAM vs. external regions, rejects unsupported external writes, bounds stuck transactions with a timeout, and blocks traffic during programming mode.

---
 rtl/storage_arbiter.sv | 177 +++++++++++++++++
 tb/tb_storage_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_arbiter.sv
// Round-robin two-port arbiter in front of storage_controller: grants one
// transaction at a time, holds it downstream and returns a registered response.
module storage_arbiter #(
  parameter int          MEM_W      = 32,
  parameter logic [31:0] SRAM_LIMIT = 32'h0000_1000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_mode,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [1:0][31:0]      addr_i,
  input  logic [1:0][MEM_W-1:0] wdata_i,
  input  logic [1:0][MEM_W/8-1:0] be_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [MEM_W-1:0]      rdata_o,
  output logic                  rerr_o,
  output logic                  memory_access,
  output logic                  memory_is_writing,
  output logic [31:0]           addr,
  output logic [MEM_W-1:0]      d_in,
  output logic [MEM_W/8-1:0]    mem_be,
  output logic                  external_storage_access,
  input  logic [MEM_W-1:0]      d_out,
  input  logic                  out_valid
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PROG = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [MEM_W-1:0]     wdata_q, wdata_d;
  logic [MEM_W/8-1:0]   be_q, be_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [MEM_W-1:0]     rdata_q, rdata_d;
  logic                 rerr_q, rerr_d;
  logic [1:0]           gnt_s;
  logic                 winner_s;
  logic                 busy_s;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    gnt_s    = 2'b00;
    // On a tie the port that did not win last time goes first.
    if (req_i == 2'b11) begin
      winner_s = ~last_q;
    end else begin
      winner_s = req_i[1];
    end

    case (state_q)
      IDLE: begin
        if (prog_mode) begin
          state_d = PROG;
        end else if (req_i != 2'b00) begin
          gnt_s[winner_s] = 1'b1;
          owner_d = winner_s;
          last_d  = winner_s;
          we_d    = we_i[winner_s];
          addr_d  = addr_i[winner_s];
          wdata_d = wdata_i[winner_s];
          be_d    = be_i[winner_s];
          cnt_d   = {CNT_W{1'b0}};
          // External storage is read-only: answer with an error, never go downstream.
          if (we_i[winner_s] && (addr_i[winner_s] >= SRAM_LIMIT)) begin
            rvalid_d[winner_s] = 1'b1;
            rerr_d  = 1'b1;
            rdata_d = {MEM_W{1'b0}};
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (prog_mode) begin
          rvalid_d[owner_q] = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = {MEM_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = PROG;
        end else if (out_valid) begin
          rvalid_d[owner_q] = 1'b1;
          rerr_d  = 1'b0;
          rdata_d = d_out;
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rvalid_d[owner_q] = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = {MEM_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      PROG: begin
        if (!prog_mode) begin
          state_d = IDLE;
        end else begin
          state_d = PROG;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= {MEM_W{1'b0}};
      be_q     <= {(MEM_W/8){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      rvalid_q <= 2'b00;
      rdata_q  <= {MEM_W{1'b0}};
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  // Downstream sees the held transaction only while BUSY, zero otherwise.
  assign busy_s                  = (state_q == BUSY);
  assign gnt_o                   = rst ? gnt_s : 2'b00;
  assign rvalid_o                = rvalid_q;
  assign rdata_o                 = rdata_q;
  assign rerr_o                  = rerr_q;
  assign memory_access           = busy_s;
  assign memory_is_writing       = busy_s & we_q;
  assign addr                    = busy_s ? addr_q : 32'd0;
  assign d_in                    = busy_s ? wdata_q : {MEM_W{1'b0}};
  assign mem_be                  = busy_s ? be_q : {(MEM_W/8){1'b0}};
  assign external_storage_access = busy_s & (addr_q >= SRAM_LIMIT);

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter; responses are checked against a
// scoreboard queue filled when each request is driven.
module tb_storage_arbiter;
  localparam int TO = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, prog_mode, out_valid;
  logic [1:0]       req_i, we_i, gnt_o, rvalid_o;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [1:0][3:0]  be_i;
  logic [31:0]      rdata_o, addr, d_in, d_out;
  logic [3:0]       mem_be;
  logic             rerr_o, memory_access, memory_is_writing, external_storage_access;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        rerr;
    bit          chk_data;
  } exp_t;
  exp_t exp_q[$];

  storage_arbiter #(.MEM_W(32), .SRAM_LIMIT(32'h0000_1000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o),
    .memory_access(memory_access), .memory_is_writing(memory_is_writing),
    .addr(addr), .d_in(d_in), .mem_be(mem_be),
    .external_storage_access(external_storage_access),
    .d_out(d_out), .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic [31:0] rd, input logic re, input bit cd);
    exp_t e;
    e.port = port;
    e.rdata = rd;
    e.rerr = re;
    e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt_o), 64'h0);
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'h0);
    check({tag, "_ma"}, 64'(memory_access), 64'h0);
    check({tag, "_mw"}, 64'(memory_is_writing), 64'h0);
    check({tag, "_addr"}, 64'(addr), 64'h0);
    check({tag, "_din"}, 64'(d_in), 64'h0);
    check({tag, "_be"}, 64'(mem_be), 64'h0);
    check({tag, "_ext"}, 64'(external_storage_access), 64'h0);
    check({tag, "_rdata"}, 64'(rdata_o), 64'h0);
    check({tag, "_rerr"}, 64'(rerr_o), 64'h0);
  endtask

  task automatic do_reset;
    rst = 1'b0; prog_mode = 1'b0; req_i = 2'b00; we_i = 2'b00;
    out_valid = 1'b0; d_out = 32'h0;
    cyc; cyc; smp;
    check_idle_outputs("reset");
    cyc;
    rst = 1'b1;
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && rvalid_o !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(rvalid_o), 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("sb_port", 64'(rvalid_o), 64'(2'b01 << e.port));
        if (e.chk_data) check("sb_rdata", 64'(rdata_o), 64'(e.rdata));
        check("sb_rerr", 64'(rerr_o), 64'(e.rerr));
      end
    end
  end

  initial begin
    int w;
    rst = 1'b0; prog_mode = 1'b0; req_i = 2'b00; we_i = 2'b00;
    addr_i = '0; wdata_i = '0; be_i = '0; out_valid = 1'b0; d_out = 32'h0;
    do_reset;

    // Single SRAM read on port 0.
    req_i = 2'b01; addr_i[0] = 32'h40; be_i[0] = 4'hF;
    push(0, 32'hDEADBEEF, 1'b0, 1'b1);
    smp; check("t1_gnt", 64'(gnt_o), 64'h1); check("t1_ma_n", 64'(memory_access), 64'h0);
    cyc; req_i = 2'b00;
    smp; check("t1_ma", 64'(memory_access), 64'h1); check("t1_addr", 64'(addr), 64'h40);
    check("t1_mw", 64'(memory_is_writing), 64'h0); check("t1_be", 64'(mem_be), 64'hF);
    check("t1_ext", 64'(external_storage_access), 64'h0);
    cyc; out_valid = 1'b1; d_out = 32'hDEADBEEF;
    smp; check("t1_rv_early", 64'(rvalid_o), 64'h0);
    cyc; out_valid = 1'b0; d_out = 32'h0;
    smp; check("t1_rvalid", 64'(rvalid_o), 64'h1); check("t1_ma_done", 64'(memory_access), 64'h0);
    cyc;
    smp; check("t1_rv_pulse", 64'(rvalid_o), 64'h0); check("t1_rdata_hold", 64'(rdata_o), 64'hDEADBEEF);

    // Both ports requesting continuously from reset: 0,1,0,1.
    do_reset;
    req_i = 2'b11; we_i = 2'b01;
    addr_i[0] = 32'h10; wdata_i[0] = 32'h11112222; be_i[0] = 4'h3;
    addr_i[1] = 32'h20; wdata_i[1] = 32'h0; be_i[1] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      push(w, 32'hA5A50000 + 32'(k), 1'b0, w == 1);
      smp; check("t2_gnt", 64'(gnt_o), 64'(2'b01 << w));
      if (k > 0) check("t2_rv_prev", 64'(rvalid_o), 64'(2'b01 << (1 - w)));
      cyc; if (k == 3) req_i = 2'b00;
      smp; check("t2_ma", 64'(memory_access), 64'h1);
      check("t2_addr", 64'(addr), (w == 1) ? 64'h20 : 64'h10);
      check("t2_mw", 64'(memory_is_writing), (w == 0) ? 64'h1 : 64'h0);
      check("t2_be", 64'(mem_be), (w == 0) ? 64'h3 : 64'hF);
      if (w == 0) check("t2_din", 64'(d_in), 64'h11112222);
      check("t2_gnt_busy", 64'(gnt_o), 64'h0);
      cyc; out_valid = 1'b1; d_out = 32'hA5A50000 + 32'(k);
      smp; check("t2_addr_stable", 64'(addr), (w == 1) ? 64'h20 : 64'h10);
      cyc; out_valid = 1'b0; d_out = 32'h0;
    end
    smp; check("t2_rv_last", 64'(rvalid_o), 64'h2); check("t2_gnt_none", 64'(gnt_o), 64'h0);

    // External read with a slow device, then a rejected external write.
    cyc; req_i = 2'b10; we_i = 2'b00; addr_i[1] = 32'h2000;
    push(1, 32'hCAFEF00D, 1'b0, 1'b1);
    smp; check("t3_gnt", 64'(gnt_o), 64'h2);
    cyc; req_i = 2'b00;
    for (int i = 0; i < 20; i++) begin
      smp; check("t3_ext", 64'(external_storage_access), 64'h1);
      check("t3_ma", 64'(memory_access), 64'h1); check("t3_rv_wait", 64'(rvalid_o), 64'h0);
      cyc;
    end
    out_valid = 1'b1; d_out = 32'hCAFEF00D;
    smp; check("t3_ext_last", 64'(external_storage_access), 64'h1);
    cyc; out_valid = 1'b0; d_out = 32'h0; req_i = 2'b10; we_i = 2'b10;
    push(1, 32'h0, 1'b1, 1'b0);
    smp; check("t3_rvalid", 64'(rvalid_o), 64'h2); check("t3_wgnt", 64'(gnt_o), 64'h2);
    check("t3_w_ma", 64'(memory_access), 64'h0);
    cyc; req_i = 2'b01; we_i = 2'b00; addr_i[0] = 32'h80;
    push(0, 32'h12345678, 1'b0, 1'b1);
    smp; check("t3_wrej_rv", 64'(rvalid_o), 64'h2); check("t3_wrej_err", 64'(rerr_o), 64'h1);
    check("t3_wrej_ma", 64'(memory_access), 64'h0); check("t3_next_gnt", 64'(gnt_o), 64'h1);
    cyc; req_i = 2'b00;
    smp; check("t3_next_addr", 64'(addr), 64'h80); check("t3_next_ext", 64'(external_storage_access), 64'h0);
    cyc; out_valid = 1'b1; d_out = 32'h12345678;
    smp;
    cyc; out_valid = 1'b0; d_out = 32'h0;
    smp; check("t3_next_rv", 64'(rvalid_o), 64'h1);

    // Timeout with no downstream answer, then a stray completion.
    cyc; req_i = 2'b01; addr_i[0] = 32'h100;
    push(0, 32'h0, 1'b1, 1'b1);
    smp; check("t4_gnt", 64'(gnt_o), 64'h1);
    cyc; req_i = 2'b00;
    for (int i = 1; i <= TO; i++) begin
      smp; check("t4_rv_wait", 64'(rvalid_o), 64'h0); check("t4_ma", 64'(memory_access), 64'h1);
      cyc;
    end
    smp; check("t4_rvalid", 64'(rvalid_o), 64'h1); check("t4_ma_done", 64'(memory_access), 64'h0);
    cyc; cyc; cyc; out_valid = 1'b1; d_out = 32'hFFFFFFFF;
    smp; check("t4_stray_ma", 64'(memory_access), 64'h0);
    cyc; out_valid = 1'b0; d_out = 32'h0;
    smp; check("t4_stray_rv", 64'(rvalid_o), 64'h0); check("t4_stray_rdata", 64'(rdata_o), 64'h0);

    // Programming mode aborts BUSY even when out_valid coincides.
    cyc; req_i = 2'b10; addr_i[1] = 32'h30;
    push(1, 32'h0, 1'b1, 1'b0);
    smp; check("t5_gnt", 64'(gnt_o), 64'h2);
    cyc; req_i = 2'b00;
    smp; check("t5_ma", 64'(memory_access), 64'h1);
    cyc; prog_mode = 1'b1; out_valid = 1'b1; d_out = 32'h5555;
    smp;
    cyc; out_valid = 1'b0; d_out = 32'h0; req_i = 2'b01; addr_i[0] = 32'h44;
    smp; check("t5_rvalid", 64'(rvalid_o), 64'h2); check("t5_rerr", 64'(rerr_o), 64'h1);
    check("t5_gnt_prog", 64'(gnt_o), 64'h0); check("t5_ma_prog", 64'(memory_access), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc; smp; check("t5_gnt_hold", 64'(gnt_o), 64'h0); check("t5_ma_hold", 64'(memory_access), 64'h0);
    end
    cyc; prog_mode = 1'b0;
    smp; check("t5_gnt_fall", 64'(gnt_o), 64'h0);
    cyc; push(0, 32'h77, 1'b0, 1'b1);
    smp; check("t5_gnt_resume", 64'(gnt_o), 64'h1);
    cyc; req_i = 2'b00;
    smp; check("t5_addr", 64'(addr), 64'h44);
    cyc; out_valid = 1'b1; d_out = 32'h77;
    smp;
    cyc; out_valid = 1'b0; d_out = 32'h0;
    smp; check("t5_rv_resume", 64'(rvalid_o), 64'h1);

    // Reset in the middle of BUSY drops the transaction silently.
    cyc; req_i = 2'b01; addr_i[0] = 32'h50;
    smp; check("t6_gnt", 64'(gnt_o), 64'h1);
    cyc; req_i = 2'b00; rst = 1'b0;
    smp; check("t6_ma_before", 64'(memory_access), 64'h1);
    cyc; out_valid = 1'b1; req_i = 2'b11;
    smp; check_idle_outputs("t6_rst");
    cyc; rst = 1'b1; out_valid = 1'b0; we_i = 2'b00;
    addr_i[0] = 32'h60; addr_i[1] = 32'h64;
    push(0, 32'hAAAA0001, 1'b0, 1'b1);
    smp; check("t6_tie_gnt", 64'(gnt_o), 64'h1);
    cyc; req_i = 2'b10;
    smp; check("t6_addr0", 64'(addr), 64'h60);
    cyc; out_valid = 1'b1; d_out = 32'hAAAA0001;
    smp;
    cyc; out_valid = 1'b0; d_out = 32'h0;
    push(1, 32'hAAAA0002, 1'b0, 1'b1);
    smp; check("t6_rv0", 64'(rvalid_o), 64'h1); check("t6_gnt1", 64'(gnt_o), 64'h2);
    cyc; req_i = 2'b00;
    smp; check("t6_addr1", 64'(addr), 64'h64);
    cyc; out_valid = 1'b1; d_out = 32'hAAAA0002;
    smp;
    cyc; out_valid = 1'b0; d_out = 32'h0;
    smp; check("t6_rv1", 64'(rvalid_o), 64'h2);
    cyc; smp;

    check("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
